// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - burst read/write controller for a synchronous single-port SRAM
module sram_ctrl #(
  parameter int DEPTH = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Start,
  input  logic       WE_req,
  input  logic [7:0] Dir_ini,
  input  logic [3:0] Cnt,
  input  logic [7:0] Dato_w,
  input  logic       Dato_w_valid,
  output logic       Dato_w_rdy,
  output logic [7:0] Dato_r,
  output logic       Dato_r_valid,
  output logic       Busy,
  output logic       Done,
  output logic       Err,
  output logic       En,
  output logic       WE,
  output logic [7:0] Dir,
  output logic [7:0] Dato_e,
  input  logic [7:0] Dato_s
);

  typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

  state_t     state, state_nx;
  logic [7:0] addr, addr_nx;
  logic [3:0] rem, rem_nx;
  logic [7:0] dir_hold, dato_e_hold;
  logic       err_nx, en_c, we_c, rdy_c;
  logic [8:0] end_addr;
  logic       bad_req, active;

  // Nine-bit sum so a burst running past address 255 is still caught.
  assign end_addr = {1'b0, Dir_ini} + {5'b0, Cnt};
  assign bad_req  = (Cnt == 4'd0) || (end_addr > 9'(DEPTH));
  assign active   = (state == RD) || (state == WR);

  always_comb begin
    state_nx = state;
    addr_nx  = addr;
    rem_nx   = rem;
    err_nx   = 1'b0;
    en_c     = 1'b0;
    we_c     = 1'b0;
    rdy_c    = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          if (bad_req) begin
            err_nx = 1'b1;
          end else begin
            addr_nx  = Dir_ini;
            rem_nx   = Cnt;
            state_nx = WE_req ? WR : RD;
          end
        end
      end
      RD: begin
        en_c    = 1'b1;
        addr_nx = addr + 8'd1;
        rem_nx  = rem - 4'd1;
        if (rem == 4'd1) state_nx = FIN;
      end
      WR: begin
        rdy_c = 1'b1;
        en_c  = Dato_w_valid;
        we_c  = Dato_w_valid;
        if (Dato_w_valid) begin
          addr_nx = addr + 8'd1;
          rem_nx  = rem - 4'd1;
          if (rem == 4'd1) state_nx = FIN;
        end
      end
      FIN: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Strobes are gated by reset so an abort never lets a stray write through.
  assign En         = en_c & ~rst;
  assign WE         = we_c & ~rst;
  assign Dato_w_rdy = rdy_c & ~rst;
  assign Dir        = active ? addr : dir_hold;
  assign Dato_e     = (state == WR) ? Dato_w : dato_e_hold;
  assign Dato_r     = Dato_s;
  assign Busy       = (state != IDLE);
  assign Done       = (state == FIN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      addr         <= 8'd0;
      rem          <= 4'd0;
      Dato_r_valid <= 1'b0;
      Err          <= 1'b0;
      dir_hold     <= 8'd0;
      dato_e_hold  <= 8'd0;
    end else begin
      state        <= state_nx;
      addr         <= addr_nx;
      rem          <= rem_nx;
      Err          <= err_nx;
      Dato_r_valid <= En & ~WE;
      if (active) dir_hold <= addr;
      if (state == WR) dato_e_hold <= Dato_w;
    end
  end

endmodule
